// File: rtl/uart_tx_sched.sv
// uart_tx_sched
// -------------
// Shares a single uart_tx transmitter between two byte requesters. Each
// accepted byte goes out as a two-byte frame: a per-requester tag byte
// followed by the data byte. The block walks uart_tx through its
// tx_send / sending handshake for both bytes and arbitrates round-robin
// when both requesters are waiting.
//
// Parameters
//   TAG0          : tag byte sent ahead of requester-0 data
//   TAG1          : tag byte sent ahead of requester-1 data
//   START_TIMEOUT : clocks to wait for tx_sending to rise after tx_send (>= 2)
//
// Ports
//   clk, rst      : clock and asynchronous active-high reset
//   en            : arbitration enable (blocks new grants only)
//   req0_valid/data/ready : requester 0 handshake (ready is a 1-cycle pulse)
//   req1_valid/data/ready : requester 1 handshake
//   tx_d_in       : byte presented to uart_tx.d_in
//   tx_send       : one-cycle start pulse to uart_tx
//   tx_sending    : uart_tx busy indication
//   busy          : a frame is in progress
//   frame_done    : one-cycle pulse after the data byte has been shifted out
//   err           : sticky start-timeout flag
//   err_clr       : clears err (a simultaneous timeout wins)
module uart_tx_sched #(
  parameter logic [7:0]  TAG0          = 8'hA0,
  parameter logic [7:0]  TAG1          = 8'hB0,
  parameter int unsigned START_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic [7:0] tx_d_in,
  output logic       tx_send,
  input  logic       tx_sending,
  output logic       busy,
  output logic       frame_done,
  output logic       err,
  input  logic       err_clr
);

  localparam int unsigned CNT_W = $clog2(START_TIMEOUT + 1);
  // Last count value before the timeout fires: the timeout edge is the one
  // on which the count would reach START_TIMEOUT.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(START_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    TAG_PULSE    = 3'd1,
    TAG_WAIT_HI  = 3'd2,
    TAG_WAIT_LO  = 3'd3,
    DATA_PULSE   = 3'd4,
    DATA_WAIT_HI = 3'd5,
    DATA_WAIT_LO = 3'd6
  } state_t;

  // Tag byte that heads a frame for the given source.
  function automatic logic [7:0] tag_for(input logic src);
    logic [7:0] tag;
    if (src) begin
      tag = TAG1;
    end else begin
      tag = TAG0;
    end
    return tag;
  endfunction

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             last_grant_r, last_grant_s;
  logic [7:0]       data_r, data_s;
  logic [7:0]       tx_d_in_r, tx_d_in_s;
  logic             tx_send_r, tx_send_s;
  logic             req0_ready_r, req0_ready_s;
  logic             req1_ready_r, req1_ready_s;
  logic             busy_r, busy_s;
  logic             frame_done_r, frame_done_s;
  logic             err_r, err_s;
  logic             timeout_s;
  logic             win_s;

  // Round-robin winner among the requesters that are valid right now.
  always_comb begin
    win_s = 1'b0;
    if (req0_valid && req1_valid) begin
      win_s = ~last_grant_r;
    end else if (req1_valid) begin
      win_s = 1'b1;
    end else begin
      win_s = 1'b0;
    end
  end

  // Next-state and next-output logic of the frame sequencer.
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    last_grant_s = last_grant_r;
    data_s       = data_r;
    tx_d_in_s    = tx_d_in_r;
    tx_send_s    = 1'b0;
    req0_ready_s = 1'b0;
    req1_ready_s = 1'b0;
    frame_done_s = 1'b0;
    timeout_s    = 1'b0;

    case (state_r)
      IDLE: begin
        // tx_sending may still be high from a transfer we did not start
        // (e.g. one cut off by reset), so never grant until it is low.
        if (en && !tx_sending && (req0_valid || req1_valid)) begin
          state_s      = TAG_PULSE;
          last_grant_s = win_s;
          tx_d_in_s    = tag_for(win_s);
          req0_ready_s = ~win_s;
          req1_ready_s = win_s;
          if (win_s) begin
            data_s = req1_data;
          end else begin
            data_s = req0_data;
          end
        end else begin
          state_s = IDLE;
        end
      end

      TAG_PULSE: begin
        // tx_send is registered, so it is high during the following cycle.
        tx_send_s = 1'b1;
        cnt_s     = CNT_ZERO;
        state_s   = TAG_WAIT_HI;
      end

      TAG_WAIT_HI: begin
        if (tx_sending) begin
          cnt_s   = CNT_ZERO;
          state_s = TAG_WAIT_LO;
        end else if (cnt_r == CNT_LAST) begin
          cnt_s     = CNT_ZERO;
          timeout_s = 1'b1;
          state_s   = IDLE;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end

      TAG_WAIT_LO: begin
        if (!tx_sending) begin
          tx_d_in_s = data_r;
          state_s   = DATA_PULSE;
        end else begin
          state_s = TAG_WAIT_LO;
        end
      end

      DATA_PULSE: begin
        tx_send_s = 1'b1;
        cnt_s     = CNT_ZERO;
        state_s   = DATA_WAIT_HI;
      end

      DATA_WAIT_HI: begin
        if (tx_sending) begin
          cnt_s   = CNT_ZERO;
          state_s = DATA_WAIT_LO;
        end else if (cnt_r == CNT_LAST) begin
          cnt_s     = CNT_ZERO;
          timeout_s = 1'b1;
          state_s   = IDLE;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end

      DATA_WAIT_LO: begin
        if (!tx_sending) begin
          frame_done_s = 1'b1;
          state_s      = IDLE;
        end else begin
          state_s = DATA_WAIT_LO;
        end
      end

      default: begin
        cnt_s   = CNT_ZERO;
        state_s = IDLE;
      end
    endcase
  end

  // Sticky error flag; a timeout in the same cycle as err_clr keeps it set.
  always_comb begin
    err_s = err_r;
    if (timeout_s) begin
      err_s = 1'b1;
    end else if (err_clr) begin
      err_s = 1'b0;
    end else begin
      err_s = err_r;
    end
  end

  // busy is registered from the next state so it rises on the grant edge.
  always_comb begin
    busy_s = (state_s != IDLE);
  end

  // State, timeout counter and latched frame contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      cnt_r        <= CNT_ZERO;
      last_grant_r <= 1'b1;
      data_r       <= 8'h00;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      last_grant_r <= last_grant_s;
      data_r       <= data_s;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_d_in_r    <= 8'h00;
      tx_send_r    <= 1'b0;
      req0_ready_r <= 1'b0;
      req1_ready_r <= 1'b0;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      tx_d_in_r    <= tx_d_in_s;
      tx_send_r    <= tx_send_s;
      req0_ready_r <= req0_ready_s;
      req1_ready_r <= req1_ready_s;
      busy_r       <= busy_s;
      frame_done_r <= frame_done_s;
      err_r        <= err_s;
    end
  end

  assign tx_d_in    = tx_d_in_r;
  assign tx_send    = tx_send_r;
  assign req0_ready = req0_ready_r;
  assign req1_ready = req1_ready_r;
  assign busy       = busy_r;
  assign frame_done = frame_done_r;
  assign err        = err_r;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: a behavioural uart_tx stand-in,
// a passive monitor that records transmitted bytes, and one task per
// scenario comparing against expectations derived from the framing and
// round-robin rules.
module tb_uart_tx_sched;

  localparam logic [7:0] TAG0 = 8'hA0;
  localparam logic [7:0] TAG1 = 8'hB0;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       req0_valid = 1'b0;
  logic [7:0] req0_data = 8'h00;
  logic       req0_ready;
  logic       req1_valid = 1'b0;
  logic [7:0] req1_data = 8'h00;
  logic       req1_ready;
  logic [7:0] tx_d_in;
  logic       tx_send;
  logic       tx_sending = 1'b0;
  logic       busy;
  logic       frame_done;
  logic       err;
  logic       err_clr = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  uart_tx_sched #(.TAG0(8'hA0), .TAG1(8'hB0), .START_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .en(en),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .tx_d_in(tx_d_in), .tx_send(tx_send), .tx_sending(tx_sending),
    .busy(busy), .frame_done(frame_done), .err(err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  // uart_tx stand-in: mode 0 = normal (sending rises one cycle after
  // tx_send and stays high hold_len cycles), 1 = dead, 2 = forced busy.
  int   uart_mode = 0;
  int   hold_len = 10;
  int   hold = 0;
  logic pend = 1'b0;
  always @(posedge clk) begin
    if (uart_mode == 2) begin
      tx_sending <= 1'b1; hold <= 0; pend <= 1'b0;
    end else if (uart_mode == 1) begin
      tx_sending <= 1'b0; hold <= 0; pend <= 1'b0;
    end else begin
      if (pend) begin
        tx_sending <= 1'b1; hold <= hold_len - 1;
      end else if (tx_sending) begin
        if (hold == 0) tx_sending <= 1'b0;
        else hold <= hold - 1;
      end
      pend <= tx_send;
    end
  end

  // Monitor: bytes sent, pulse counts, tx_d_in stability while a byte is out.
  logic [7:0] sent_q[$];
  int r0_cnt = 0, r1_cnt = 0, fd_cnt = 0, viol = 0;
  logic stab_arm = 1'b0, stab_hi = 1'b0;
  logic [7:0] stab_val = 8'h00;
  always @(negedge clk) begin
    if (req0_ready === 1'b1) r0_cnt++;
    if (req1_ready === 1'b1) r1_cnt++;
    if (frame_done === 1'b1) fd_cnt++;
    if (tx_send === 1'b1) begin
      sent_q.push_back(tx_d_in);
      stab_arm = 1'b1; stab_hi = 1'b0; stab_val = tx_d_in;
    end else if (stab_arm) begin
      if (busy !== 1'b1) begin
        stab_arm = 1'b0;
      end else begin
        if (tx_d_in !== stab_val) viol++;
        if (tx_sending) stab_hi = 1'b1;
        else if (stab_hi) stab_arm = 1'b0;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic mon_clear();
    sent_q.delete();
    r0_cnt = 0; r1_cnt = 0; fd_cnt = 0; viol = 0; stab_arm = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; err_clr = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    mon_clear();
  endtask

  task automatic test_reset();
    rst = 1'b1; uart_mode = 0;
    repeat (3) tick();
    n_checks++; if (tx_send !== 1'b0) begin n_errors++; $display("FAIL reset_tx_send: got %b want 0", tx_send); end
    n_checks++; if (tx_d_in !== 8'h00) begin n_errors++; $display("FAIL reset_tx_d_in: got %h want 00", tx_d_in); end
    n_checks++; if (req0_ready !== 1'b0) begin n_errors++; $display("FAIL reset_req0_ready: got %b want 0", req0_ready); end
    n_checks++; if (req1_ready !== 1'b0) begin n_errors++; $display("FAIL reset_req1_ready: got %b want 0", req1_ready); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (frame_done !== 1'b0) begin n_errors++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
    n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL reset_err: got %b want 0", err); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    logic [7:0] exp_q[$];
    bit found;
    do_reset();
    hold_len = 10;
    en = 1'b1; req0_data = 8'h70; req0_valid = 1'b1;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin tick(); if (req0_ready) found = 1; end
    n_checks++; if (!found) begin n_errors++; $display("FAIL single_ready: no req0_ready within 10 cycles"); end
    n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL single_busy_grant: got %b want 1", busy); end
    req0_valid = 1'b0; req0_data = 8'h00;
    tick();
    n_checks++; if (tx_send !== 1'b1) begin n_errors++; $display("FAIL single_send_timing: got %b want 1", tx_send); end
    n_checks++; if (tx_d_in !== TAG0) begin n_errors++; $display("FAIL single_tag: got %h want %h", tx_d_in, TAG0); end
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin tick(); if (frame_done) found = 1; end
    n_checks++; if (!found) begin n_errors++; $display("FAIL single_frame_done: not seen within 200 cycles"); end
    repeat (4) tick();
    exp_q.push_back(TAG0); exp_q.push_back(8'h70);
    n_checks++; if (sent_q.size() != exp_q.size()) begin n_errors++; $display("FAIL single_send_count: got %0d want %0d", sent_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= sent_q.size() || sent_q[i] !== exp_q[i]) begin
        n_errors++; $display("FAIL single_byte%0d: got %h want %h", i, (i < sent_q.size()) ? sent_q[i] : 8'hxx, exp_q[i]);
      end
    end
    n_checks++; if (r0_cnt != 1 || r1_cnt != 0) begin n_errors++; $display("FAIL single_ready_count: got r0=%0d r1=%0d want 1/0", r0_cnt, r1_cnt); end
    n_checks++; if (fd_cnt != 1) begin n_errors++; $display("FAIL single_done_count: got %0d want 1", fd_cnt); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL single_busy_after: got %b want 0", busy); end
    n_checks++; if (viol != 0) begin n_errors++; $display("FAIL single_stability: got %0d changes want 0", viol); end
  endtask

  task automatic test_tie();
    logic [7:0] exp_q[$];
    logic last, w;
    int frames;
    do_reset();
    hold_len = 10;
    en = 1'b1; req0_data = 8'h11; req1_data = 8'h22; req0_valid = 1'b1; req1_valid = 1'b1;
    frames = 0;
    for (int i = 0; i < 600 && frames < 4; i++) begin
      tick();
      if (frame_done) begin frames++; if (frames == 4) en = 1'b0; end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    n_checks++; if (frames != 4) begin n_errors++; $display("FAIL tie_frames: got %0d want 4", frames); end
    repeat (5) tick();
    // Both always valid: each grant goes to the requester not served last.
    last = 1'b1;
    for (int f = 0; f < 4; f++) begin
      w = ~last;
      exp_q.push_back(w ? TAG1 : TAG0);
      exp_q.push_back(w ? 8'h22 : 8'h11);
      last = w;
    end
    n_checks++; if (sent_q.size() != exp_q.size()) begin n_errors++; $display("FAIL tie_send_count: got %0d want %0d", sent_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= sent_q.size() || sent_q[i] !== exp_q[i]) begin
        n_errors++; $display("FAIL tie_byte%0d: got %h want %h", i, (i < sent_q.size()) ? sent_q[i] : 8'hxx, exp_q[i]);
      end
    end
    n_checks++; if (r0_cnt != 2 || r1_cnt != 2) begin n_errors++; $display("FAIL tie_ready_count: got r0=%0d r1=%0d want 2/2", r0_cnt, r1_cnt); end
  endtask

  task automatic test_timeout();
    bit found;
    int n;
    do_reset();
    uart_mode = 1;
    en = 1'b1; req1_data = 8'h5C; req1_valid = 1'b1;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin tick(); if (req1_ready) found = 1; end
    n_checks++; if (!found) begin n_errors++; $display("FAIL timeout_ready: no req1_ready within 10 cycles"); end
    req1_valid = 1'b0;
    tick();
    n_checks++; if (tx_send !== 1'b1 || tx_d_in !== TAG1) begin n_errors++; $display("FAIL timeout_tag_send: got send=%b d=%h want 1/%h", tx_send, tx_d_in, TAG1); end
    n = 0;
    for (int i = 1; i <= 40 && n == 0; i++) begin tick(); if (err) n = i; end
    n_checks++; if (n != 16) begin n_errors++; $display("FAIL timeout_latency: got %0d cycles want 16", n); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL timeout_idle: busy got %b want 0", busy); end
    repeat (3) tick();
    n_checks++; if (err !== 1'b1) begin n_errors++; $display("FAIL timeout_sticky: err got %b want 1", err); end
    n_checks++; if (fd_cnt != 0) begin n_errors++; $display("FAIL timeout_no_done: got %0d want 0", fd_cnt); end
    n_checks++; if (sent_q.size() != 1) begin n_errors++; $display("FAIL timeout_send_count: got %0d want 1", sent_q.size()); end
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL timeout_clear: err got %b want 0", err); end
    // Second timeout with err_clr held: the timeout edge still sets err.
    err_clr = 1'b1; req1_valid = 1'b1;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin tick(); if (req1_ready) found = 1; end
    req1_valid = 1'b0;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin tick(); if (err) found = 1; end
    n_checks++; if (!found) begin n_errors++; $display("FAIL timeout_vs_clear: err got 0 want 1 on timeout"); end
    tick();
    n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL timeout_clear_after: err got %b want 0", err); end
    err_clr = 1'b0; en = 1'b0; uart_mode = 0;
    repeat (3) tick();
  endtask

  task automatic test_en_low();
    bit found;
    int sends;
    do_reset();
    hold_len = 10;
    en = 1'b0; req0_data = 8'h33; req1_data = 8'h44; req0_valid = 1'b1; req1_valid = 1'b1;
    repeat (30) tick();
    n_checks++; if (r0_cnt + r1_cnt != 0 || sent_q.size() != 0) begin n_errors++; $display("FAIL en_low_blocked: got ready=%0d sends=%0d want 0/0", r0_cnt + r1_cnt, sent_q.size()); end
    en = 1'b1;
    sends = 0;
    for (int i = 0; i < 120 && sends < 2; i++) begin tick(); if (tx_send) sends++; end
    n_checks++; if (sends != 2) begin n_errors++; $display("FAIL en_low_data_send: got %0d sends want 2", sends); end
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin tick(); if (tx_sending) found = 1; end
    tick();
    en = 1'b0;
    found = 0;
    for (int i = 0; i < 50 && !found; i++) begin tick(); if (frame_done) found = 1; end
    n_checks++; if (!found) begin n_errors++; $display("FAIL en_low_complete: frame_done not seen within 50 cycles"); end
    repeat (40) tick();
    n_checks++; if (r0_cnt != 1 || r1_cnt != 0) begin n_errors++; $display("FAIL en_low_no_regrant: got r0=%0d r1=%0d want 1/0", r0_cnt, r1_cnt); end
    n_checks++; if (sent_q.size() != 2 || busy !== 1'b0) begin n_errors++; $display("FAIL en_low_idle: got sends=%0d busy=%b want 2/0", sent_q.size(), busy); end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit found;
    do_reset();
    hold_len = 10;
    en = 1'b1; req0_data = 8'h3C; req0_valid = 1'b1;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin tick(); if (req0_ready) found = 1; end
    req0_valid = 1'b0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin tick(); if (tx_sending) found = 1; end
    n_checks++; if (!found) begin n_errors++; $display("FAIL rmid_sending: tx_sending never rose"); end
    tick();
    uart_mode = 2;
    rst = 1'b1;
    #1;
    n_checks++; if (tx_send !== 1'b0 || tx_d_in !== 8'h00) begin n_errors++; $display("FAIL rmid_tx_outputs: got send=%b d=%h want 0/00", tx_send, tx_d_in); end
    n_checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin n_errors++; $display("FAIL rmid_ready: got %b%b want 00", req0_ready, req1_ready); end
    n_checks++; if (busy !== 1'b0 || frame_done !== 1'b0 || err !== 1'b0) begin n_errors++; $display("FAIL rmid_status: got busy=%b done=%b err=%b want 0/0/0", busy, frame_done, err); end
    tick();
    rst = 1'b0;
    req0_data = 8'h3C; req1_data = 8'h4D; req0_valid = 1'b1; req1_valid = 1'b1;
    mon_clear();
    repeat (20) tick();
    n_checks++; if (r0_cnt + r1_cnt != 0 || sent_q.size() != 0) begin n_errors++; $display("FAIL rmid_no_grant_busy: got ready=%0d sends=%0d want 0/0", r0_cnt + r1_cnt, sent_q.size()); end
    uart_mode = 0;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin tick(); if (req0_ready || req1_ready) found = 1; end
    n_checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin n_errors++; $display("FAIL rmid_first_tie: got r0=%b r1=%b want 1/0", req0_ready, req1_ready); end
    req0_valid = 1'b0; req1_valid = 1'b0; en = 1'b0;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin tick(); if (!busy) found = 1; end
    n_checks++; if (!found) begin n_errors++; $display("FAIL rmid_finish: busy still 1 after 200 cycles"); end
    repeat (15) tick();
  endtask

  task automatic test_data_stability();
    logic [7:0] q0[$], q1[$], exp_q[$];
    logic prev, w, ew;
    int frames;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      q0.push_back(8'($urandom_range(0, 255)));
      q1.push_back(8'($urandom_range(0, 255)));
    end
    prev = 1'b1; frames = 0; en = 1'b1;
    for (int cyc = 0; cyc < 4000 && frames < 20; cyc++) begin
      tick();
      if (frame_done) frames++;
      if (req0_ready || req1_ready) begin
        w = req1_ready;
        n_checks++; if (req0_ready && req1_ready) begin n_errors++; $display("FAIL rand_dual_ready: both readies high"); end
        if (req0_valid && req1_valid) ew = ~prev;
        else if (req1_valid) ew = 1'b1;
        else ew = 1'b0;
        n_checks++; if (w !== ew) begin n_errors++; $display("FAIL rand_arb: got requester %0d want %0d", w, ew); end
        exp_q.push_back(w ? TAG1 : TAG0);
        if (w && q1.size() > 0) begin exp_q.push_back(q1[0]); void'(q1.pop_front()); req1_valid = 1'b0; end
        else if (!w && q0.size() > 0) begin exp_q.push_back(q0[0]); void'(q0.pop_front()); req0_valid = 1'b0; end
        else begin exp_q.push_back(8'h00); end
        prev = w;
        hold_len = $urandom_range(2, 12);
      end
      if (!req0_valid && q0.size() > 0 && $urandom_range(0, 2) == 0) begin req0_valid = 1'b1; req0_data = q0[0]; end
      if (!req1_valid && q1.size() > 0 && $urandom_range(0, 2) == 0) begin req1_valid = 1'b1; req1_data = q1[0]; end
    end
    n_checks++; if (frames != 20) begin n_errors++; $display("FAIL rand_frames: got %0d want 20", frames); end
    repeat (4) tick();
    n_checks++; if (sent_q.size() != 40) begin n_errors++; $display("FAIL rand_send_count: got %0d want 40", sent_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= sent_q.size() || sent_q[i] !== exp_q[i]) begin
        n_errors++; $display("FAIL rand_byte%0d: got %h want %h", i, (i < sent_q.size()) ? sent_q[i] : 8'hxx, exp_q[i]);
      end
    end
    n_checks++; if (viol != 0) begin n_errors++; $display("FAIL rand_stability: tx_d_in changed %0d times while sending, want 0", viol); end
    n_checks++; if (fd_cnt != 20) begin n_errors++; $display("FAIL rand_done_count: got %0d want 20", fd_cnt); end
    en = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_timeout();
    test_en_low();
    test_reset_mid();
    test_data_stability();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
